// File: rtl/fp_mul_arbiter.sv
// Round-robin scheduler sharing one pipelined FP16 multiplier
// among NUM_REQ requesters; products return tagged to their owner.
module fp_mul_arbiter #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          mul_en,
  output logic [DATA_WIDTH-1:0]         mul_a,
  output logic [DATA_WIDTH-1:0]         mul_b,
  input  logic [DATA_WIDTH-1:0]         mul_result,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          busy
);

  localparam int IW    = $clog2(NUM_REQ);
  localparam int DEPTH = MUL_LATENCY + 1;

  logic [IW-1:0]         last_grant;
  logic [IW-1:0]         sel;
  logic                  found;
  logic                  xfer;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    iss_tag;
  logic [DEPTH-1:0]      vld_q;
  logic [NUM_REQ-1:0]    tag_q [DEPTH];
  logic [DATA_WIDTH-1:0] sel_a;
  logic [DATA_WIDTH-1:0] sel_b;

  // search starts one past the last winner and wraps
  always_comb begin
    found = 1'b0;
    sel   = last_grant;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found &&
          req_valid[(int'(last_grant) + k) % NUM_REQ]) begin
        found = 1'b1;
        sel   = IW'((int'(last_grant) + k) % NUM_REQ);
      end
    end
  end

  assign gnt       = NUM_REQ'(1) << sel;
  assign xfer      = found & reset;
  assign req_ready = xfer ? gnt : '0;
  assign sel_a     = req_a[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_b     = req_b[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
  assign busy      = mul_en | (|vld_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= IW'(NUM_REQ - 1);
      mul_en     <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      iss_tag    <= '0;
    end else begin
      mul_en <= xfer;
      if (xfer) begin
        last_grant <= sel;
        mul_a      <= sel_a;
        mul_b      <= sel_b;
        iss_tag    <= gnt;
      end
    end
  end

  // tag pipe tracks the multiplier, stage 0 samples with its en
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      vld_q[0] <= mul_en;
      tag_q[0] <= iss_tag;
      for (int k = 1; k < DEPTH; k++) begin
        vld_q[k] <= vld_q[k-1];
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else if (vld_q[DEPTH-1]) begin
      rsp_valid <= tag_q[DEPTH-1];
      rsp_data  <= mul_result;
    end else begin
      rsp_valid <= '0;
    end
  end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter: behavioural scoreboard plus
// directed scenarios with literal expectations.
module tb_fp_mul_arbiter;

  localparam int N = 4;
  localparam int W = 16;
  localparam int L = 1;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic           mul_en;
  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_b;
  logic [W-1:0]   mul_result;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_data;
  logic           busy;

  int errors = 0;
  int checks = 0;

  fp_mul_arbiter #(
    .DATA_WIDTH(W), .NUM_REQ(N), .MUL_LATENCY(L)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready),
    .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b),
    .mul_result(mul_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // FP16 multiply for normal operands, truncating
  function automatic logic [15:0] fmul(input logic [15:0] a,
                                       input logic [15:0] b);
    logic        s;
    int          e;
    logic [21:0] m;
    logic [9:0]  fr;
    s = a[15] ^ b[15];
    e = int'(a[14:10]) + int'(b[14:10]) - 15;
    m = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
    if (m[21]) begin
      e++;
      fr = m[20:11];
    end else begin
      fr = m[19:10];
    end
    return {s, e[4:0], fr};
  endfunction

  // multiplier stand-in: garbage whenever its output is not valid
  logic [L:0]   mv = '0;
  logic [W-1:0] mp [0:L];
  always @(posedge clk) begin
    mv <= {mv[L-1:0], mul_en};
    for (int k = L; k > 0; k--) mp[k] <= mp[k-1];
    mp[0] <= fmul(mul_a, mul_b);
  end
  assign mul_result = mv[L] ? mp[L] : 16'hDEAD;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [N-1:0] tag;
    logic [W-1:0] prod;
    int           due;
  } op_t;

  op_t          q[$];
  int           ptr = N - 1;
  int           cyc = 0;
  logic         exp_en = 1'b0;
  logic [W-1:0] exp_a = '0;
  logic [W-1:0] exp_b = '0;
  logic [W-1:0] exp_rd = '0;

  function automatic int mgrant(input logic [N-1:0] v, input int p);
    for (int k = 1; k <= N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    if (reset) begin
      cyc++;
      g = mgrant(req_valid, ptr);
      exp_en = 1'b0;
      if (g >= 0) begin
        ptr    = g;
        exp_en = 1'b1;
        exp_a  = req_a[g*W +: W];
        exp_b  = req_b[g*W +: W];
        q.push_back('{tag: N'(1) << g,
                      prod: fmul(exp_a, exp_b),
                      due: cyc + L + 2});
      end
    end
  end

  always @(negedge clk) begin
    int           g;
    logic [N-1:0] erv;
    logic         eb;
    if (!reset) begin
      ptr = N - 1;
      q.delete();
      exp_en = 1'b0;
      exp_a  = '0;
      exp_b  = '0;
      exp_rd = '0;
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_mul_en", 32'(mul_en), 0);
      chk("rst_mul_a", 32'(mul_a), 0);
      chk("rst_mul_b", 32'(mul_b), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_data", 32'(rsp_data), 0);
      chk("rst_busy", 32'(busy), 0);
    end else begin
      g = mgrant(req_valid, ptr);
      chk("req_ready", 32'(req_ready),
          g >= 0 ? 32'(N'(1) << g) : 32'd0);
      chk("mul_en", 32'(mul_en), 32'(exp_en));
      chk("mul_a", 32'(mul_a), 32'(exp_a));
      chk("mul_b", 32'(mul_b), 32'(exp_b));
      erv = '0;
      eb  = 1'b0;
      foreach (q[i]) begin
        if (q[i].due == cyc) begin
          erv    = q[i].tag;
          exp_rd = q[i].prod;
        end
        if (q[i].due > cyc) eb = 1'b1;
      end
      while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
      chk("rsp_valid", 32'(rsp_valid), 32'(erv));
      chk("rsp_data", 32'(rsp_data), 32'(exp_rd));
      chk("busy", 32'(busy), 32'(eb | exp_en));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  logic [W-1:0] ba [4] = '{16'h4000, 16'h4200, 16'h4400, 16'h3C00};
  logic [W-1:0] bb [4] = '{16'h4000, 16'h4000, 16'h3800, 16'hC200};
  logic [W-1:0] bp [4] = '{16'h4400, 16'h4600, 16'h4000, 16'hC200};

  initial begin
    reset     = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < N; i++) begin
      set_op(i, 16'h3C00 + 16'(i << 10), 16'h4000);
    end
    chk("model_pin", 32'(fmul(16'h4200, 16'hC600)), 32'hCC80);

    // reset held with everyone valid, then release
    repeat (3) tick();
    @(negedge clk);
    chk("lit_rst_ready", 32'(req_ready), 0);
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("lit_first_grant", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    repeat (5) tick();

    // single op from requester 2
    set_op(2, 16'h4200, 16'hC600);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("lit_single_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("lit_single_en", 32'(mul_en), 1);
    chk("lit_single_a", 32'(mul_a), 32'h4200);
    repeat (3) tick();
    @(negedge clk);
    chk("lit_single_rv", 32'(rsp_valid), 32'b0100);
    chk("lit_single_rd", 32'(rsp_data), 32'hCC80);
    tick();
    @(negedge clk);
    chk("lit_single_rv_off", 32'(rsp_valid), 0);
    chk("lit_single_idle", 32'(busy), 0);
    tick();

    // full contention from a fresh pointer
    pulse_reset();
    for (int i = 0; i < N; i++) begin
      set_op(i, ba[i], bb[(i + 1) % 4]);
    end
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("lit_rotate", 32'(req_ready), 32'(N'(1) << (k % N)));
      tick();
    end
    req_valid = '0;
    repeat (5) tick();

    // pointer persistence
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    repeat (3) tick();
    req_valid = 4'b0011;
    @(negedge clk);
    chk("lit_persist", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    repeat (5) tick();

    // reset while two ops are in flight
    req_valid = 4'b0001;
    repeat (2) tick();
    req_valid = '0;
    tick();
    pulse_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("lit_flush_rv", 32'(rsp_valid), 0);
      chk("lit_flush_busy", 32'(busy), 0);
      tick();
    end

    // back-to-back from requester 3
    req_valid = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      set_op(3, ba[k], bb[k]);
      tick();
    end
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("lit_b2b_rv", 32'(rsp_valid), 32'b1000);
      chk("lit_b2b_rd", 32'(rsp_data), 32'(bp[k]));
      tick();
    end
    @(negedge clk);
    chk("lit_b2b_end", 32'(rsp_valid), 0);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_mul_arbiter.md
# fp_mul_arbiter

Round-robin scheduler that shares one pipelined FP16 `floating_point_multiplayer` instance among `NUM_REQ` requesters, such as PE rows or the accumulate path. It accepts operand pairs over per-requester valid/ready handshakes and issues at most one multiply per cycle. Each in-flight operation carries a one-hot requester tag through a shift register matched to the multiplier latency, and every product is routed back to its originating requester. The block sits between the TPU compute scheduler and the multiplier datapath.

## Interface
- `DATA_WIDTH`, 16: operand/result width, IEEE-754 half.
- `NUM_REQ`, 4: number of requesters, 2..8.
- `MUL_LATENCY`, 1: cycles from the edge that samples `mul_en` to valid `mul_result`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low. `reset`=0 clears all state immediately.
- `req_valid` in NUM_REQ: operand pair offered by requester i.
- `req_a`, `req_b` in NUM_REQ*DATA_WIDTH: packed operands; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready` out NUM_REQ: one-hot grant; a transfer occurs when `req_valid[i] && req_ready[i]` at the edge.
- `mul_en` out 1: registered issue strobe to the multiplier `en`.
- `mul_a`, `mul_b` out DATA_WIDTH: registered operands to the multiplier.
- `mul_result` in DATA_WIDTH: multiplier output.
- `rsp_valid` out NUM_REQ: registered one-hot; product for requester i is on `rsp_data` this cycle.
- `rsp_data` out DATA_WIDTH: registered product.
- `busy` out 1: high while any operation is issued or in flight.

## Operation
- **Arbitration (combinational).** The search for a valid requester starts at `last_grant+1` and wraps modulo NUM_REQ. The first valid requester found gets `req_ready`. At most one `req_ready` bit is high, and it is never high while that requester's `req_valid` is low. `req_ready` is all zeros while `reset`=0.
- **`last_grant` update.** `last_grant` updates only on a completed transfer. Its reset value is NUM_REQ-1, so requester 0 wins first. With no valid requesters, `last_grant` holds.
- **Issue stage.** On a transfer, the selected operands are latched into `mul_a`/`mul_b`, `mul_en` is set to 1, and the one-hot tag enters stage 0 of the tag pipe. With no transfer, `mul_en` is 0 and `mul_a`/`mul_b` hold their previous values.
- **Tag pipe.** The tag pipe is MUL_LATENCY+1 entries, each holding a valid bit and a NUM_REQ one-hot tag. It shifts every cycle; there is no stall, so the multiplier is never backpressured.
- **Response stage.** When the tail entry is valid, the block registers `rsp_valid` <= tail tag and `rsp_data` <= `mul_result`. Otherwise `rsp_valid` <= 0 and `rsp_data` holds. Responses have no backpressure: requesters must accept them in the cycle they appear.
- **Ordering.** Responses leave in issue order. A requester issuing back-to-back receives its results back-to-back.
- **Arithmetic.** The block performs none; operands and results pass through bit-exact.
- **`busy`.** `busy` = `mul_en` OR any tag-pipe valid bit.
- **Reset.** Asserting `reset` mid-operation clears the tag pipe, `mul_en`, `rsp_valid`, `mul_a`/`mul_b`/`rsp_data` (to 0), and `last_grant`. Products of operations in flight before reset are dropped and never signalled.

## Timing
- **Reset values.** `req_ready`=0, `mul_en`=0, `mul_a`=`mul_b`=0, `rsp_valid`=0, `rsp_data`=0, `busy`=0.
- **Latency.** A transfer at edge E0 gives `mul_en`=1 in cycle E0..E1. `mul_result` is valid MUL_LATENCY cycles after E1. `rsp_valid` is high for exactly one cycle, MUL_LATENCY+2 cycles after E0 (3 cycles at the default).
- **Throughput.** One operation per cycle, sustained, for any mix of requesters.
- **Fairness.** With all NUM_REQ requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0,… A continuously valid requester waits at most NUM_REQ-1 cycles.
- **Simultaneous events.**
  - A new transfer and a response in the same cycle are independent.
  - A requester may issue in the same cycle it receives a response.
  - Deasserting `req_valid` while not granted is legal and causes no issue.
- **Reset release.** After `reset` returns to 1, the first grant may occur in the same cycle, following the arbitration rule.

## Test plan
- **Reset.** Hold `reset`=0 with all `req_valid`=1 -> all outputs 0 and `req_ready`=0; on release, `req_ready`=4'b0001.
- **Single op.** Requester 2 only, a=16'h4200 (3), b=16'hC600 (-6), transfer at E0 -> `mul_en`=1 with matching operands next cycle; `rsp_valid`=4'b0100 and `rsp_data`=16'hCC80 (-18) exactly 3 cycles after E0, for one cycle; `busy` falls afterwards.
- **Full contention.** All 4 valid for 8 cycles with distinct operands -> grants 0,1,2,3,0,1,2,3; `mul_en` high all 8 cycles; responses return in the same tag order with the correct products.
- **Pointer persistence.** Grant requester 1, idle 3 cycles, then requesters 0 and 1 both valid -> requester 0 is granted first.
- **Reset mid-flight.** Issue 2 ops, then pulse `reset`=0 one cycle later -> no `rsp_valid` ever appears for those ops; `busy`=0.
- **Back-to-back same requester.** Requester 3 alone, valid 4 cycles -> 4 consecutive `rsp_valid`=4'b1000 cycles with results in order.
